// File: rtl/des_dispatch_pkg.sv
// des_dispatch_pkg
// Shared types and constants for the DES job dispatcher.
//   slot_state_t        : per-slot lifecycle (IDLE -> BUSY -> DONE -> IDLE)
//   BLOCK_WIDTH_DEFAULT : plaintext/key/ciphertext width
//   MAX_ENGINES         : largest supported engine count
package des_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } slot_state_t;

    localparam int BLOCK_WIDTH_DEFAULT = 64;
    localparam int MAX_ENGINES         = 16;

endpackage

// File: rtl/des_dispatch_slot.sv
// des_dispatch_slot
// One dispatcher slot bound to one des_core. Holds the slot FSM, the job
// plaintext/key presented to the engine, the captured ciphertext and the
// one-cycle start strobe.
//
// Optional build macro: DES_DISPATCH_STATS_EN adds the spurious_done output.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   accept          : job handshake targets this slot this cycle
//   retire          : result handshake targets this slot this cycle
//   done_strobe     : engine done pulse
//   plaintext, key  : job data from the input stream
//   eng_ciphertext  : engine result data
//   start_strobe    : one-cycle engine start pulse (cycle after accept)
//   eng_plaintext,
//   eng_key         : data held for the engine while the slot is in use
//   result          : captured ciphertext
//   state           : current slot state (also the debug view of the FSM)
//   spurious_done   : done pulse seen while not BUSY (stats build only)
module des_dispatch_slot
    import des_dispatch_pkg::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   accept,
    input  logic                   retire,
    input  logic                   done_strobe,
    input  logic [BLOCK_WIDTH-1:0] plaintext,
    input  logic [BLOCK_WIDTH-1:0] key,
    input  logic [BLOCK_WIDTH-1:0] eng_ciphertext,
    output logic                   start_strobe,
    output logic [BLOCK_WIDTH-1:0] eng_plaintext,
    output logic [BLOCK_WIDTH-1:0] eng_key,
    output logic [BLOCK_WIDTH-1:0] result,
    output slot_state_t            state
`ifdef DES_DISPATCH_STATS_EN
    ,
    output logic                   spurious_done
`endif
);

    slot_state_t            state_q;
    slot_state_t            state_d;
    logic                   start_q;
    logic [BLOCK_WIDTH-1:0] pt_q;
    logic [BLOCK_WIDTH-1:0] key_q;
    logic [BLOCK_WIDTH-1:0] result_q;
    logic                   take;
    logic                   capture;

    // The top only asserts accept/retire in the matching state; the gating
    // here keeps the slot self-consistent regardless.
    assign take    = accept && (state_q == IDLE);
    assign capture = done_strobe && (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = BUSY;
            BUSY:    if (done_strobe) state_d = DONE;
            DONE:    if (retire)      state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            pt_q     <= '0;
            key_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= take;
            if (take) begin
                pt_q  <= plaintext;
                key_q <= key;
            end
            if (capture) begin
                result_q <= eng_ciphertext;
            end
        end
    end

    assign start_strobe  = start_q;
    assign eng_plaintext = pt_q;
    assign eng_key       = key_q;
    assign result        = result_q;
    assign state         = state_q;

`ifdef DES_DISPATCH_STATS_EN
    // Late strobes after reset and strobes on DONE slots are dropped.
    assign spurious_done = done_strobe && (state_q != BUSY);
`endif

endmodule

// File: rtl/des_dispatch_array.sv
// des_dispatch_array
// Dispatches a single valid/ready job stream round-robin over NUM_ENGINES
// des_core engines and returns ciphertexts on a valid/ready result stream
// in job-acceptance order (round-robin collection mirrors dispatch).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; ready never depends on valid, and valid/data hold until
// the transfer.
//
// Optional build macro: DES_DISPATCH_STATS_EN adds saturating counters
// jobs_in_count_dout, jobs_out_count_dout, spurious_done_count_dout.
//
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   job_valid_din/job_ready_dout : job stream handshake
//   plaintext_din, key_din       : job data
//   result_valid_dout/result_ready_din, ciphertext_dout : result stream
//   eng_start_strobe_dout        : per-engine start pulse
//   eng_plaintext_dout, eng_key_dout : per-engine data, slice i = engine i
//   eng_done_strobe_din, eng_active_din, eng_ciphertext_din : engine status
//   inflight_count_dout          : number of non-IDLE slots (registered)
module des_dispatch_array
    import des_dispatch_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEFAULT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               job_valid_din,
    output logic                               job_ready_dout,
    input  logic [BLOCK_WIDTH-1:0]             plaintext_din,
    input  logic [BLOCK_WIDTH-1:0]             key_din,
    output logic                               result_valid_dout,
    input  logic                               result_ready_din,
    output logic [BLOCK_WIDTH-1:0]             ciphertext_dout,
    output logic [NUM_ENGINES-1:0]             eng_start_strobe_dout,
    output logic [NUM_ENGINES*BLOCK_WIDTH-1:0] eng_plaintext_dout,
    output logic [NUM_ENGINES*BLOCK_WIDTH-1:0] eng_key_dout,
    input  logic [NUM_ENGINES-1:0]             eng_done_strobe_din,
    input  logic [NUM_ENGINES-1:0]             eng_active_din,
    input  logic [NUM_ENGINES*BLOCK_WIDTH-1:0] eng_ciphertext_din,
    output logic [$clog2(NUM_ENGINES+1)-1:0]   inflight_count_dout
`ifdef DES_DISPATCH_STATS_EN
    ,
    output logic [31:0]                        jobs_in_count_dout,
    output logic [31:0]                        jobs_out_count_dout,
    output logic [15:0]                        spurious_done_count_dout
`endif
);

    localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int CW = $clog2(NUM_ENGINES + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_ENGINES - 1);

    logic [PW-1:0]          dp;
    logic [PW-1:0]          cp;
    slot_state_t            slot_state  [NUM_ENGINES];
    logic [BLOCK_WIDTH-1:0] slot_result [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] slot_accept;
    logic [NUM_ENGINES-1:0] slot_retire;
    logic                   ready_sel;
    logic                   valid_sel;
    logic [BLOCK_WIDTH-1:0] cipher_sel;
    logic                   accept;
    logic                   retire;

    // Ready/valid come only from registered slot state, so a slot released
    // this cycle cannot be re-dispatched until the next one (no bypass).
    always_comb begin
        ready_sel  = 1'b0;
        valid_sel  = 1'b0;
        cipher_sel = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (dp == PW'(i)) begin
                ready_sel = (slot_state[i] == IDLE) && !eng_active_din[i];
            end
            if (cp == PW'(i)) begin
                valid_sel  = (slot_state[i] == DONE);
                cipher_sel = slot_result[i];
            end
        end
    end

    assign job_ready_dout    = ready_sel;
    assign result_valid_dout = valid_sel;
    assign ciphertext_dout   = cipher_sel;
    assign accept            = job_valid_din && ready_sel;
    assign retire            = valid_sel && result_ready_din;

`ifdef DES_DISPATCH_STATS_EN
    logic [NUM_ENGINES-1:0] slot_spurious;
`endif

    for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
        assign slot_accept[i] = accept && (dp == PW'(i));
        assign slot_retire[i] = retire && (cp == PW'(i));

        des_dispatch_slot #(
            .BLOCK_WIDTH (BLOCK_WIDTH)
        ) u_slot (
            .clk            (clk),
            .reset          (reset),
            .accept         (slot_accept[i]),
            .retire         (slot_retire[i]),
            .done_strobe    (eng_done_strobe_din[i]),
            .plaintext      (plaintext_din),
            .key            (key_din),
            .eng_ciphertext (eng_ciphertext_din[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .start_strobe   (eng_start_strobe_dout[i]),
            .eng_plaintext  (eng_plaintext_dout[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .eng_key        (eng_key_dout[i*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .result         (slot_result[i]),
            .state          (slot_state[i])
`ifdef DES_DISPATCH_STATS_EN
            ,
            .spurious_done  (slot_spurious[i])
`endif
        );
    end

    // Accept and retire may hit different slots in one cycle; they cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp                  <= '0;
            cp                  <= '0;
            inflight_count_dout <= '0;
        end else begin
            if (accept) begin
                dp <= (dp == LAST_IDX) ? '0 : dp + PW'(1);
            end
            if (retire) begin
                cp <= (cp == LAST_IDX) ? '0 : cp + PW'(1);
            end
            case ({accept, retire})
                2'b10:   inflight_count_dout <= inflight_count_dout + CW'(1);
                2'b01:   inflight_count_dout <= inflight_count_dout - CW'(1);
                default: inflight_count_dout <= inflight_count_dout;
            endcase
        end
    end

`ifdef DES_DISPATCH_STATS_EN
    localparam int SCW = $clog2(MAX_ENGINES + 1);

    logic [SCW-1:0] spurious_n;
    logic [16:0]    spurious_sum;

    // Several engines can strobe spuriously in the same cycle.
    always_comb begin
        spurious_n = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            spurious_n = spurious_n + SCW'(slot_spurious[i]);
        end
        spurious_sum = {1'b0, spurious_done_count_dout} + 17'(spurious_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            jobs_in_count_dout       <= '0;
            jobs_out_count_dout      <= '0;
            spurious_done_count_dout <= '0;
        end else begin
            if (accept && (jobs_in_count_dout != '1)) begin
                jobs_in_count_dout <= jobs_in_count_dout + 32'd1;
            end
            if (retire && (jobs_out_count_dout != '1)) begin
                jobs_out_count_dout <= jobs_out_count_dout + 32'd1;
            end
            spurious_done_count_dout <= spurious_sum[16] ? 16'hFFFF : spurious_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_des_dispatch_array.sv
// tb_des_dispatch_array
// Bench for des_dispatch_array: a 4-engine instance driven through a stub
// engine model with per-engine latency, plus a 1-engine instance driven by
// hand for the release/dispatch collision on a single slot.
module tb_des_dispatch_array;

    localparam int N  = 4;
    localparam int BW = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- 4-engine DUT ----------------
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [BW-1:0]     plaintext = '0;
    logic [BW-1:0]     key = '0;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic [BW-1:0]     ciphertext;
    logic [N-1:0]      eng_start;
    logic [N*BW-1:0]   eng_pt;
    logic [N*BW-1:0]   eng_key;
    logic [N-1:0]      eng_done;
    logic [N-1:0]      stub_done = '0;
    logic [N-1:0]      man_done = '0;
    logic [N-1:0]      eng_active = '0;
    logic [N*BW-1:0]   eng_ct = '0;
    logic [2:0]        inflight;
`ifdef DES_DISPATCH_STATS_EN
    logic [31:0]       jobs_in;
    logic [31:0]       jobs_out;
    logic [15:0]       spurious;
`endif

    assign eng_done = stub_done | man_done;

    des_dispatch_array #(.NUM_ENGINES(N), .BLOCK_WIDTH(BW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .job_valid_din         (job_valid),
        .job_ready_dout        (job_ready),
        .plaintext_din         (plaintext),
        .key_din               (key),
        .result_valid_dout     (result_valid),
        .result_ready_din      (result_ready),
        .ciphertext_dout       (ciphertext),
        .eng_start_strobe_dout (eng_start),
        .eng_plaintext_dout    (eng_pt),
        .eng_key_dout          (eng_key),
        .eng_done_strobe_din   (eng_done),
        .eng_active_din        (eng_active),
        .eng_ciphertext_din    (eng_ct),
        .inflight_count_dout   (inflight)
`ifdef DES_DISPATCH_STATS_EN
        ,
        .jobs_in_count_dout       (jobs_in),
        .jobs_out_count_dout      (jobs_out),
        .spurious_done_count_dout (spurious)
`endif
    );

    // ---------------- 1-engine DUT ----------------
    logic          j1_valid = 1'b0;
    logic          j1_ready;
    logic [BW-1:0] pt1 = '0;
    logic [BW-1:0] key1 = '0;
    logic          r1_valid;
    logic          r1_ready = 1'b0;
    logic [BW-1:0] c1;
    logic [0:0]    s1_start;
    logic [BW-1:0] ep1;
    logic [BW-1:0] ek1;
    logic [0:0]    d1_done = 1'b0;
    logic [0:0]    a1_active = 1'b0;
    logic [BW-1:0] c1_in = '0;
    logic [0:0]    inflight1;
`ifdef DES_DISPATCH_STATS_EN
    logic [31:0]   jobs_in1;
    logic [31:0]   jobs_out1;
    logic [15:0]   spurious1;
`endif

    des_dispatch_array #(.NUM_ENGINES(1), .BLOCK_WIDTH(BW)) dut1 (
        .clk                   (clk),
        .reset                 (reset),
        .job_valid_din         (j1_valid),
        .job_ready_dout        (j1_ready),
        .plaintext_din         (pt1),
        .key_din               (key1),
        .result_valid_dout     (r1_valid),
        .result_ready_din      (r1_ready),
        .ciphertext_dout       (c1),
        .eng_start_strobe_dout (s1_start),
        .eng_plaintext_dout    (ep1),
        .eng_key_dout          (ek1),
        .eng_done_strobe_din   (d1_done),
        .eng_active_din        (a1_active),
        .eng_ciphertext_din    (c1_in),
        .inflight_count_dout   (inflight1)
`ifdef DES_DISPATCH_STATS_EN
        ,
        .jobs_in_count_dout       (jobs_in1),
        .jobs_out_count_dout      (jobs_out1),
        .spurious_done_count_dout (spurious1)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stub engine function: the real DES vector for the reference job,
    // a cheap xor for everything else.
    function automatic logic [63:0] cipher_of(input logic [63:0] pt, input logic [63:0] k);
        if (pt == 64'h0123456789ABCDEF && k == 64'h133457799BBCDFF1)
            return 64'h85E813540F0AB405;
        return pt ^ k;
    endfunction

    // ---------------- scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    int            eng_q[$];
    int            hs_edges[$];
    int            tb_dp = 0;
    int            start_cnt[N];
    int            valid_cycles = 0;

    // ---------------- stub engines ----------------
    int            lat[N];
    int            cnt[N];
    logic [BW-1:0] spt[N];
    logic [BW-1:0] skey[N];

    initial begin
        for (int i = 0; i < N; i++) begin
            lat[i] = 3;
            cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            stub_done = '0;
            for (int i = 0; i < N; i++) begin
                if (reset) begin
                    cnt[i]        = 0;
                    eng_active[i] = 1'b0;
                end else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            stub_done[i]        = 1'b1;
                            eng_ct[i*BW +: BW]  = cipher_of(spt[i], skey[i]);
                            eng_active[i]       = 1'b0;
                        end
                    end
                    if (eng_start[i]) begin
                        cnt[i]        = lat[i];
                        spt[i]        = eng_pt[i*BW +: BW];
                        skey[i]       = eng_key[i*BW +: BW];
                        eng_active[i] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (eng_start[i]) begin
                    start_cnt[i]++;
                    check("start_pending", 64'(eng_q.size() != 0), 1);
                    if (eng_q.size() != 0) check("start_engine", i, eng_q.pop_front());
                end
            end
            if (result_valid) valid_cycles++;
            if (result_valid && result_ready) begin
                check("result_pending", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("result_data", ciphertext, exp_q.pop_front());
                hs_edges.push_back(cyc + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        reset     = 1'b1;
        job_valid = 1'b0;
        man_done  = '0;
        exp_q.delete();
        eng_q.delete();
        tb_dp = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic send_job(input logic [63:0] pt, input logic [63:0] k, output int acc_edge);
        logic acc;
        acc       = 1'b0;
        acc_edge  = -1;
        plaintext = pt;
        key       = k;
        job_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            #1;
            acc = job_ready;
            @(posedge clk);
            #1;
        end
        job_valid = 1'b0;
        check("job_accepted", acc, 1);
        if (acc) begin
            exp_q.push_back(cipher_of(pt, k));
            eng_q.push_back(tb_dp);
            tb_dp    = (tb_dp + 1) % N;
            acc_edge = cyc;
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) start_cnt[i] = 0;
        valid_cycles = 0;
        hs_edges.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e;
        do_reset(3);

        // Reset state
        check("rst_job_ready", job_ready, 1);
        check("rst_result_valid", result_valid, 0);
        check("rst_ciphertext", ciphertext, 0);
        check("rst_inflight", inflight, 0);
        check("rst_start", eng_start, 0);
        check("rst_eng_pt", 64'(|eng_pt), 0);

        // Single reference job
        clear_counts();
        result_ready = 1'b1;
        send_job(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, e);
        check("single_inflight_busy", inflight, 1);
        check("single_eng0_pt", eng_pt[0 +: BW], 64'h0123456789ABCDEF);
        check("single_eng0_key", eng_key[0 +: BW], 64'h133457799BBCDFF1);
        wait_drain("single_drain");
        check("single_start_eng0", start_cnt[0], 1);
        check("single_start_other", start_cnt[1] + start_cnt[2] + start_cnt[3], 0);
        check("single_valid_cycles", valid_cycles, 1);
        check("single_inflight_end", inflight, 0);

        // Eight back-to-back jobs, engine 0 slow
        do_reset(2);
        clear_counts();
        lat[0] = 12; lat[1] = 2; lat[2] = 2; lat[3] = 2;
        for (int j = 0; j < 8; j++)
            send_job(64'h1000 + 64'(j), 64'hFEDCBA9876543210, e);
        wait_drain("burst_drain");
        for (int i = 0; i < N; i++) check("burst_start_cnt", start_cnt[i], 2);
        check("burst_inflight_end", inflight, 0);

        // Back-pressure: fill all slots, then release
        do_reset(2);
        clear_counts();
        for (int i = 0; i < N; i++) lat[i] = 2;
        result_ready = 1'b0;
        for (int j = 0; j < 4; j++)
            send_job(64'h0000_0000_AAAA_0000 + 64'(j), 64'h5555_0000_0000_0001, e);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("full_job_ready", job_ready, 0);
        check("full_inflight", inflight, 4);
        check("full_result_valid", result_valid, 1);
        check("full_cipher_head", ciphertext, 64'h5555_0000_AAAA_0001);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hold_result_valid", result_valid, 1);
        check("hold_cipher", ciphertext, 64'h5555_0000_AAAA_0001);
        hs_edges.delete();
        result_ready = 1'b1;
        send_job(64'h0000_0000_BBBB_0000, 64'h5555_0000_0000_0001, e);
        wait_drain("release_drain");
        check("release_hs_count", hs_edges.size(), 5);
        if (hs_edges.size() >= 4) begin
            check("release_hs_1", hs_edges[1] - hs_edges[0], 1);
            check("release_hs_2", hs_edges[2] - hs_edges[0], 2);
            check("release_hs_3", hs_edges[3] - hs_edges[0], 3);
            check("release_dispatch_resume", e - hs_edges[0], 1);
        end

        // Spurious done on idle slot 2
        valid_cycles = 0;
        man_done = 4'b0100;
        @(posedge clk);
        #1;
        man_done = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("spur_valid_cycles", valid_cycles, 0);
        check("spur_result_valid", result_valid, 0);
        check("spur_inflight", inflight, 0);
`ifdef DES_DISPATCH_STATS_EN
        check("stats_spurious", spurious, 1);
        check("stats_jobs_in", jobs_in, 5);
        check("stats_jobs_out", jobs_out, 5);
`endif
        send_job(64'h0000_0000_CCCC_0000, 64'h0000_1111_0000_0000, e);
        wait_drain("spur_followup_drain");

        // Reset with three jobs in flight
        for (int i = 0; i < N; i++) lat[i] = 20;
        for (int j = 0; j < 3; j++)
            send_job(64'h0000_0000_DDDD_0000 + 64'(j), 64'h7777_0000_0000_0000, e);
        check("midrst_inflight_before", inflight, 3);
        do_reset(1);
        check("midrst_start", eng_start, 0);
        check("midrst_result_valid", result_valid, 0);
        check("midrst_cipher", ciphertext, 0);
        check("midrst_inflight", inflight, 0);
        check("midrst_eng_pt", 64'(|eng_pt), 0);
        check("midrst_eng_key", 64'(|eng_key), 0);
        check("midrst_job_ready", job_ready, 1);
`ifdef DES_DISPATCH_STATS_EN
        check("midrst_stats_in", jobs_in, 0);
`endif
        man_done = 4'b0111;
        @(posedge clk);
        #1;
        man_done = '0;
        @(posedge clk);
        #1;
        check("late_done_valid", result_valid, 0);
        check("late_done_inflight", inflight, 0);
        for (int i = 0; i < N; i++) lat[i] = 3;
        clear_counts();
        send_job(64'h0000_0000_EEEE_0000, 64'h0101_0101_0101_0101, e);
        wait_drain("midrst_newjob_drain");
        check("midrst_newjob_eng0", start_cnt[0], 1);

        // Single-engine release/dispatch collision
        result_ready = 1'b0;
        pt1 = 64'h0000_0000_0000_00A1;
        key1 = 64'h0000_0000_0000_00B1;
        j1_valid = 1'b1;
        @(negedge clk);
        #1;
        check("n1_ready_idle", j1_ready, 1);
        @(posedge clk);
        #1;
        j1_valid = 1'b0;
        check("n1_start", s1_start, 1);
        check("n1_inflight", inflight1, 1);
        check("n1_eng_pt", ep1, 64'h0000_0000_0000_00A1);
        @(posedge clk);
        #1;
        check("n1_start_once", s1_start, 0);
        c1_in = 64'h0000_0000_0000_C0DE;
        d1_done = 1'b1;
        @(posedge clk);
        #1;
        d1_done = 1'b0;
        check("n1_result_valid", r1_valid, 1);
        check("n1_cipher", c1, 64'h0000_0000_0000_C0DE);
        check("n1_ready_done", j1_ready, 0);
        r1_ready = 1'b1;
        pt1 = 64'h0000_0000_0000_00A2;
        j1_valid = 1'b1;
        @(negedge clk);
        #1;
        check("n1_ready_in_release_cycle", j1_ready, 0);
        @(posedge clk);
        #1;
        r1_ready = 1'b0;
        check("n1_valid_after_release", r1_valid, 0);
        check("n1_ready_after_release", j1_ready, 1);
        check("n1_inflight_after_release", inflight1, 0);
        @(posedge clk);
        #1;
        j1_valid = 1'b0;
        check("n1_redispatch_start", s1_start, 1);
        check("n1_redispatch_inflight", inflight1, 1);
        check("n1_redispatch_pt", ep1, 64'h0000_0000_0000_00A2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
